adder_txn_driver: RTL and testbench

ADDER_TXN_DRIVER -- requirements
Module: adder_txn_driver

---
 rtl/adder_txn_driver.sv | 120 ++++++++++++
 tb/tb_adder_txn_driver.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_txn_driver.sv
// Transaction driver for a pipelined adder: queues operand pairs, issues them to the adder,
// captures sums after a fixed latency, flags mismatches and returns results in order.
module adder_txn_driver #(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned ADDER_LAT = 1,
    parameter int unsigned DEPTH     = 4
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [DATA_W-1:0] req_a_i,
    input  logic [DATA_W-1:0] req_b_i,
    output logic [DATA_W-1:0] data_1_o,
    output logic [DATA_W-1:0] data_2_o,
    input  logic [DATA_W:0]   sum_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [DATA_W:0]   rsp_sum_o,
    output logic              rsp_err_o,
    input  logic              flush_i,
    output logic              busy_o
);
    localparam int unsigned AW  = $clog2(DEPTH);
    localparam int unsigned CW  = AW + 1;
    localparam int unsigned CWE = CW + 1;

    typedef enum logic [1:0] {StIdle, StRun, StFlush} state_e;
    state_e state_q;

    logic [2*DATA_W-1:0] req_mem_q [DEPTH];
    logic [AW-1:0]       req_wr_q, req_rd_q;
    logic [CW-1:0]       req_cnt_q;

    logic [DATA_W+1:0]   res_mem_q [DEPTH];
    logic [AW-1:0]       res_wr_q, res_rd_q;
    logic [CW-1:0]       res_cnt_q;

    logic [DATA_W-1:0]   data_1_q, data_2_q;
    logic                issue_vld_q;
    logic [ADDER_LAT-1:0] pipe_vld_q;
    logic [2*DATA_W-1:0] pipe_tag_q [ADDER_LAT];
    logic [CW-1:0]       inflight_q;

    logic              req_push, req_pop, res_push, res_pop, issue;
    logic [CW:0]       occupancy;
    logic [DATA_W-1:0] cap_a, cap_b;
    logic [DATA_W:0]   cap_exp;

    always_comb begin
        req_ready_o = (state_q == StRun) && (req_cnt_q != CW'(DEPTH));
        req_push    = req_valid_i && req_ready_o;
        // Reserve a result slot for every issued operand so captures never overflow.
        occupancy   = {1'b0, res_cnt_q} + {1'b0, inflight_q};
        issue       = (req_cnt_q != '0) && (occupancy < CWE'(DEPTH));
        req_pop     = issue;
        res_push    = pipe_vld_q[ADDER_LAT-1];
        {cap_a, cap_b} = pipe_tag_q[ADDER_LAT-1];
        cap_exp     = {1'b0, cap_a} + {1'b0, cap_b};
        rsp_valid_o = (res_cnt_q != '0);
        res_pop     = rsp_valid_o && rsp_ready_i;
        rsp_sum_o   = rsp_valid_o ? res_mem_q[res_rd_q][DATA_W:0] : '0;
        rsp_err_o   = rsp_valid_o && res_mem_q[res_rd_q][DATA_W+1];
        busy_o      = (req_cnt_q != '0) || (inflight_q != '0) || rsp_valid_o;
    end

    assign data_1_o = data_1_q;
    assign data_2_o = data_2_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= StIdle;
        end else begin
            unique case (state_q)
                StIdle:  state_q <= StRun;
                StRun:   if (flush_i) state_q <= StFlush;
                StFlush: if (!busy_o) state_q <= StRun;
                default: state_q <= StIdle;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            req_wr_q    <= '0;
            req_rd_q    <= '0;
            req_cnt_q   <= '0;
            res_wr_q    <= '0;
            res_rd_q    <= '0;
            res_cnt_q   <= '0;
            data_1_q    <= '0;
            data_2_q    <= '0;
            issue_vld_q <= 1'b0;
            pipe_vld_q  <= '0;
            inflight_q  <= '0;
        end else begin
            if (req_push) req_wr_q <= req_wr_q + AW'(1);
            if (req_pop)  req_rd_q <= req_rd_q + AW'(1);
            req_cnt_q <= req_cnt_q + CW'(req_push) - CW'(req_pop);
            if (issue) {data_1_q, data_2_q} <= req_mem_q[req_rd_q];
            // The issue register acts as stage zero; the shift line tracks adder latency.
            issue_vld_q <= issue;
            pipe_vld_q  <= (pipe_vld_q << 1) | ADDER_LAT'(issue_vld_q);
            inflight_q  <= inflight_q + CW'(issue) - CW'(res_push);
            if (res_push) res_wr_q <= res_wr_q + AW'(1);
            if (res_pop)  res_rd_q <= res_rd_q + AW'(1);
            res_cnt_q <= res_cnt_q + CW'(res_push) - CW'(res_pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (req_push) req_mem_q[req_wr_q] <= {req_a_i, req_b_i};
        if (res_push) res_mem_q[res_wr_q] <= {(sum_i != cap_exp), sum_i};
        pipe_tag_q[0] <= {data_1_q, data_2_q};
        for (int unsigned i = 1; i < ADDER_LAT; i++) begin
            pipe_tag_q[i] <= pipe_tag_q[i-1];
        end
    end

endmodule

// File: tb/tb_adder_txn_driver.sv
// Bench for adder_txn_driver with a latency-accurate adder model that corrupts 3+4 to zero.
module tb_adder_txn_driver;
    localparam int unsigned DW    = 8;
    localparam int unsigned LAT   = 3;
    localparam int unsigned DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid = 1'b0, req_ready;
    logic [DW-1:0] req_a = '0, req_b = '0;
    logic [DW-1:0] data_1, data_2;
    logic [DW:0]   sum;
    logic          rsp_valid, rsp_ready = 1'b0, rsp_err;
    logic [DW:0]   rsp_sum;
    logic          flush = 1'b0, busy;

    int checks = 0;
    int passed = 0;
    int n_acc  = 0;
    logic [DW+1:0] exp_q[$];

    adder_txn_driver #(.DATA_W(DW), .ADDER_LAT(LAT), .DEPTH(DEPTH)) dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_a_i(req_a), .req_b_i(req_b),
        .data_1_o(data_1), .data_2_o(data_2), .sum_i(sum),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_sum_o(rsp_sum),
        .rsp_err_o(rsp_err), .flush_i(flush), .busy_o(busy)
    );

    always #5 clk = ~clk;

    // Adder model: LAT register stages from the driven operands to sum.
    logic [DW:0] add_pipe [LAT];
    always_ff @(posedge clk) begin
        add_pipe[0] <= (data_1 == 8'd3 && data_2 == 8'd4) ? '0 : {1'b0, data_1} + {1'b0, data_2};
        for (int i = 1; i < LAT; i++) add_pipe[i] <= add_pipe[i-1];
    end
    assign sum = add_pipe[LAT-1];

    function automatic logic [DW+1:0] ref_rsp(input logic [DW-1:0] a, input logic [DW-1:0] b);
        int unsigned true_sum = int'(a) + int'(b);
        int unsigned adder_out = (a == 8'd3 && b == 8'd4) ? 0 : true_sum;
        return {adder_out != true_sum, 9'(adder_out)};
    endfunction

    // Advance one cycle, updating the reference queue; sampling happens 1ns after posedge.
    task automatic tick(output bit popped, output logic [DW+1:0] got, output logic [DW+1:0] exp);
        popped = rsp_valid && rsp_ready;
        got = {rsp_err, rsp_sum};
        exp = 'x;
        if (popped && exp_q.size() != 0) exp = exp_q.pop_front();
        if (req_valid && req_ready) begin
            exp_q.push_back(ref_rsp(req_a, req_b));
            n_acc++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        checks++; if (req_ready !== 1'b0) $display("FAIL reset_ready: got %b want 0", req_ready);
        else passed++;
        checks++; if ({data_1, data_2} !== '0) $display("FAIL reset_data: got %h want 0",
            {data_1, data_2}); else passed++;
        checks++; if (rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid: got %b want 0",
            rsp_valid); else passed++;
        checks++; if ({rsp_err, rsp_sum} !== '0) $display("FAIL reset_rsp: got %h want 0",
            {rsp_err, rsp_sum}); else passed++;
        checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy);
        else passed++;
        rst_n = 1'b1;
        #1;
        checks++; if (req_ready !== 1'b0) $display("FAIL idle_ready: got %b want 0", req_ready);
        else passed++;
        @(posedge clk);
        #1;
        checks++; if (req_ready !== 1'b1) $display("FAIL run_ready: got %b want 1", req_ready);
        else passed++;
    endtask

    task automatic test_latency();
        bit p; logic [DW+1:0] g, e, first_rsp;
        int first = -1;
        rsp_ready = 1'b1;
        req_a = 8'hFF; req_b = 8'h01; req_valid = 1'b1;
        tick(p, g, e);
        req_valid = 1'b0;
        for (int k = 0; k <= int'(LAT) + 6; k++) begin
            if (rsp_valid && first < 0) begin first = k; first_rsp = {rsp_err, rsp_sum}; end
            tick(p, g, e);
            if (p) begin
                checks++; if (g !== e) $display("FAIL latency_model: got %h want %h", g, e);
                else passed++;
            end
        end
        checks++; if (first != int'(LAT) + 2) $display("FAIL latency_cycles: got %0d want %0d",
            first, LAT + 2); else passed++;
        checks++; if (first_rsp !== {1'b0, 9'h100}) $display("FAIL latency_sum: got %h want %h",
            first_rsp, {1'b0, 9'h100}); else passed++;
    endtask

    task automatic test_err();
        bit p; logic [DW+1:0] g, e;
        bit seen = 0;
        rsp_ready = 1'b1;
        req_a = 8'd3; req_b = 8'd4; req_valid = 1'b1;
        tick(p, g, e);
        req_valid = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            tick(p, g, e);
            if (p) begin
                seen = 1;
                checks++; if (g !== {1'b1, 9'd0}) $display("FAIL err_rsp: got %h want %h", g,
                    {1'b1, 9'd0}); else passed++;
                checks++; if (g !== e) $display("FAIL err_model: got %h want %h", g, e);
                else passed++;
            end
        end
        checks++; if (!seen) $display("FAIL err_timeout: got none want 1 response"); else passed++;
    endtask

    task automatic test_backpressure();
        bit p; logic [DW+1:0] g, e;
        int acc = 0, pops = 0;
        rsp_ready = 1'b0;
        for (int n = 0; n < 40 && acc < 8; n++) begin
            req_valid = 1'b1;
            req_a = 8'($urandom_range(0, 255)); req_b = 8'($urandom_range(0, 255));
            if (req_ready) acc++;
            tick(p, g, e);
        end
        checks++; if (acc != 8) $display("FAIL bp_accepted: got %0d want 8", acc); else passed++;
        for (int n = 0; n < int'(LAT) + 4; n++) tick(p, g, e);
        checks++; if (req_ready !== 1'b0) $display("FAIL bp_ready: got %b want 0", req_ready);
        else passed++;
        checks++; if (rsp_valid !== 1'b1) $display("FAIL bp_rsp_valid: got %b want 1", rsp_valid);
        else passed++;
        checks++; if (exp_q.size() != 8) $display("FAIL bp_queued: got %0d want 8", exp_q.size());
        else passed++;
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        for (int n = 0; n < 100 && exp_q.size() > 0; n++) begin
            tick(p, g, e);
            if (p) begin
                pops++;
                checks++; if (g !== e) $display("FAIL bp_order: got %h want %h", g, e);
                else passed++;
            end
        end
        checks++; if (pops != 8) $display("FAIL bp_pops: got %0d want 8", pops); else passed++;
        checks++; if (rsp_valid !== 1'b0) $display("FAIL bp_drained: got %b want 0", rsp_valid);
        else passed++;
    endtask

    task automatic test_flush();
        bit p; logic [DW+1:0] g, e;
        int acc = 0, pops = 0, ready_seen = 0;
        rsp_ready = 1'b0;
        for (int n = 0; n < 20 && acc < 3; n++) begin
            req_valid = 1'b1;
            req_a = 8'($urandom_range(0, 255)); req_b = 8'($urandom_range(0, 255));
            if (req_ready) acc++;
            tick(p, g, e);
        end
        req_valid = 1'b0;
        flush = 1'b1;
        tick(p, g, e);
        flush = 1'b0;
        checks++; if (req_ready !== 1'b0) $display("FAIL flush_ready: got %b want 0", req_ready);
        else passed++;
        for (int n = 0; n < int'(LAT) + 4; n++) tick(p, g, e);
        checks++; if (busy !== 1'b1) $display("FAIL flush_busy: got %b want 1", busy);
        else passed++;
        rsp_ready = 1'b1;
        for (int n = 0; n < 60 && busy; n++) begin
            if (req_ready) ready_seen++;
            tick(p, g, e);
            if (p) begin
                pops++;
                checks++; if (g !== e) $display("FAIL flush_rsp: got %h want %h", g, e);
                else passed++;
            end
        end
        checks++; if (pops != 3) $display("FAIL flush_pops: got %0d want 3", pops); else passed++;
        checks++; if (ready_seen != 0) $display("FAIL flush_ready_leak: got %0d want 0",
            ready_seen); else passed++;
        checks++; if (busy !== 1'b0) $display("FAIL flush_idle: got %b want 0", busy);
        else passed++;
        checks++; if (req_ready !== 1'b0) $display("FAIL flush_exit_early: got %b want 0",
            req_ready); else passed++;
        tick(p, g, e);
        checks++; if (req_ready !== 1'b1) $display("FAIL flush_exit: got %b want 1", req_ready);
        else passed++;
    endtask

    task automatic test_random();
        bit p; logic [DW+1:0] g, e;
        int acc0 = n_acc, pops = 0, both = 0;
        for (int c = 0; c < 400; c++) begin
            req_valid = ($urandom_range(0, 3) != 0);
            req_a = 8'($urandom_range(0, 255)); req_b = 8'($urandom_range(0, 255));
            rsp_ready = ((c / 50) % 2 == 0) ? ($urandom_range(0, 3) == 0)
                                            : ($urandom_range(0, 3) != 0);
            if (req_valid && req_ready && rsp_valid && rsp_ready) both++;
            tick(p, g, e);
            if (p) begin
                pops++;
                checks++; if (g !== e) $display("FAIL rand_rsp: got %h want %h", g, e);
                else passed++;
            end
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        for (int n = 0; n < 100 && exp_q.size() > 0; n++) begin
            tick(p, g, e);
            if (p) begin
                pops++;
                checks++; if (g !== e) $display("FAIL rand_drain: got %h want %h", g, e);
                else passed++;
            end
        end
        checks++; if (pops != n_acc - acc0) $display("FAIL rand_count: got %0d want %0d", pops,
            n_acc - acc0); else passed++;
        checks++; if (pops < 10) $display("FAIL rand_volume: got %0d want >=10", pops);
        else passed++;
        checks++; if (both == 0) $display("FAIL rand_concurrent: got 0 want >0"); else passed++;
    endtask

    task automatic test_reset_mid();
        bit p; logic [DW+1:0] g, e;
        int acc = 0, spurious = 0;
        rsp_ready = 1'b0;
        for (int n = 0; n < 20 && acc < 4; n++) begin
            req_valid = 1'b1;
            req_a = 8'($urandom_range(0, 255)); req_b = 8'($urandom_range(0, 255));
            if (req_ready) acc++;
            tick(p, g, e);
        end
        req_valid = 1'b0;
        checks++; if (busy !== 1'b1) $display("FAIL mid_busy_before: got %b want 1", busy);
        else passed++;
        #3 rst_n = 1'b0;
        #1;
        checks++; if (req_ready !== 1'b0) $display("FAIL mid_ready: got %b want 0", req_ready);
        else passed++;
        checks++; if ({data_1, data_2} !== '0) $display("FAIL mid_data: got %h want 0",
            {data_1, data_2}); else passed++;
        checks++; if (rsp_valid !== 1'b0) $display("FAIL mid_rsp_valid: got %b want 0",
            rsp_valid); else passed++;
        checks++; if ({rsp_err, rsp_sum} !== '0) $display("FAIL mid_rsp: got %h want 0",
            {rsp_err, rsp_sum}); else passed++;
        checks++; if (busy !== 1'b0) $display("FAIL mid_busy: got %b want 0", busy); else passed++;
        exp_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        for (int n = 0; n < int'(LAT) + 10; n++) begin
            if (rsp_valid) spurious++;
            tick(p, g, e);
        end
        checks++; if (spurious != 0) $display("FAIL mid_ghost_rsp: got %0d want 0", spurious);
        else passed++;
        checks++; if (busy !== 1'b0) $display("FAIL mid_busy_after: got %b want 0", busy);
        else passed++;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_latency();
        test_err();
        test_backpressure();
        test_flush();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
